bp_commit_queue: RTL and testbench

- In-order tracking queue between the branch predictor's predict port (at instruction queue) and its training port (at commit).
- Records each predicted branch's PC, prediction, GHR snapshot and perceptron sum at allocation.
- At ROB branch commit, pops the oldest entry, compares the prediction against the actual outcome, and drives the predictor training request, the mispredict pulse and the recovered GHR.

---
 rtl/bp_commit_queue.sv | 194 +++++++++++++++++++
 tb/tb_bp_commit_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_commit_queue.sv
// bp_commit_queue: in-order queue between the branch predictor's predict
// port (at instruction queue) and its training port (at commit).
// Each predicted branch records its PC, prediction, GHR snapshot and
// perceptron sum. At ROB branch commit the oldest entry is popped. It then
// drives the training request, the mispredict pulse and the recovered GHR.
// Optional statistics counters are enabled with the macro BPQ_STATS_EN.
module bp_commit_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned GHR_WIDTH = 16,
    parameter int unsigned SUM_WIDTH = 8,
    parameter int unsigned THETA     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [31:0]              alloc_pc,
    input  logic                     alloc_pred,
    input  logic [GHR_WIDTH-1:0]     alloc_ghr,
    input  logic [SUM_WIDTH-1:0]     alloc_sum,
    input  logic                     commit_valid,
    input  logic                     commit_taken,
    input  logic                     flush,
    output logic                     train_valid,
    output logic [31:0]              train_pc,
    output logic                     train_taken,
    output logic [GHR_WIDTH-1:0]     train_ghr,
    output logic                     mispredict,
    output logic [GHR_WIDTH-1:0]     recover_ghr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err
`ifdef BPQ_STATS_EN
    ,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispredicts
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [SUM_WIDTH-1:0] SUM_MIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};
    localparam logic [SUM_WIDTH-1:0] SUM_MAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};

    // Entry storage; contents need no reset.
    logic [31:0]          pc_mem   [DEPTH];
    logic                 pred_mem [DEPTH];
    logic [GHR_WIDTH-1:0] ghr_mem  [DEPTH];
    logic [SUM_WIDTH-1:0] sum_mem  [DEPTH];

    logic [PW:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]          wr_ptr_q, wr_ptr_d;
    logic                 train_valid_q, train_valid_d;
    logic [31:0]          train_pc_q, train_pc_d;
    logic                 train_taken_q, train_taken_d;
    logic [GHR_WIDTH-1:0] train_ghr_q, train_ghr_d;
    logic                 mispredict_q, mispredict_d;
    logic [GHR_WIDTH-1:0] recover_ghr_q, recover_ghr_d;
    logic                 underflow_err_q, underflow_err_d;

    logic                 empty, full, do_alloc, do_pop, mis, train;
    logic [PW-1:0]        rd_idx, wr_idx;
    logic [31:0]          ent_pc;
    logic                 ent_pred;
    logic [GHR_WIDTH-1:0] ent_ghr;
    logic [SUM_WIDTH-1:0] ent_sum;
    logic [SUM_WIDTH-1:0] mag;

    assign rd_idx   = rd_ptr_q[PW-1:0];
    assign wr_idx   = wr_ptr_q[PW-1:0];
    assign ent_pc   = pc_mem[rd_idx];
    assign ent_pred = pred_mem[rd_idx];
    assign ent_ghr  = ghr_mem[rd_idx];
    assign ent_sum  = sum_mem[rd_idx];

    // Occupancy flags, handshake and commit decision for this cycle.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_idx == rd_idx) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
        do_alloc = alloc_valid && !full;
        do_pop   = commit_valid && !empty;
        mis      = do_pop && (ent_pred != commit_taken);
        if (ent_sum == SUM_MIN) begin
            mag = SUM_MAX;
        end else if (ent_sum[SUM_WIDTH-1]) begin
            mag = SUM_WIDTH'(-ent_sum);
        end else begin
            mag = ent_sum;
        end
        train    = mis || (32'(mag) <= 32'(THETA));
    end

    // Next pointers and registered training/recovery outputs.
    always_comb begin
        rd_ptr_d        = do_pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d        = do_alloc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        // A mispredict or flush discards everything younger than the popped
        // entry, including any same-cycle allocation.
        if (mis || flush) begin
            wr_ptr_d = rd_ptr_d;
        end
        train_valid_d   = do_pop && train;
        mispredict_d    = mis;
        train_pc_d      = train_pc_q;
        train_taken_d   = train_taken_q;
        train_ghr_d     = train_ghr_q;
        recover_ghr_d   = recover_ghr_q;
        if (do_pop && train) begin
            train_pc_d    = ent_pc;
            train_taken_d = commit_taken;
            train_ghr_d   = ent_ghr;
        end
        if (mis) begin
            recover_ghr_d = {ent_ghr[GHR_WIDTH-2:0], commit_taken};
        end
        underflow_err_d = underflow_err_q || (commit_valid && empty);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            train_valid_q   <= 1'b0;
            train_pc_q      <= '0;
            train_taken_q   <= 1'b0;
            train_ghr_q     <= '0;
            mispredict_q    <= 1'b0;
            recover_ghr_q   <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            train_valid_q   <= train_valid_d;
            train_pc_q      <= train_pc_d;
            train_taken_q   <= train_taken_d;
            train_ghr_q     <= train_ghr_d;
            mispredict_q    <= mispredict_d;
            recover_ghr_q   <= recover_ghr_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    // Entry write on an accepted allocation.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            pc_mem[wr_idx]   <= alloc_pc;
            pred_mem[wr_idx] <= alloc_pred;
            ghr_mem[wr_idx]  <= alloc_ghr;
            sum_mem[wr_idx]  <= alloc_sum;
        end
    end

    assign alloc_ready   = !full;
    assign count         = wr_ptr_q - rd_ptr_q;
    assign train_valid   = train_valid_q;
    assign train_pc      = train_pc_q;
    assign train_taken   = train_taken_q;
    assign train_ghr     = train_ghr_q;
    assign mispredict    = mispredict_q;
    assign recover_ghr   = recover_ghr_q;
    assign underflow_err = underflow_err_q;

`ifdef BPQ_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Saturating commit and mispredict counters.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (do_pop && (stat_branches_q != '1)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (mis && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_bp_commit_queue.sv
// Directed bench for bp_commit_queue with hand-computed expectations.
module tb_bp_commit_queue;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic [15:0] alloc_ghr;
    logic [7:0]  alloc_sum;
    logic        commit_valid;
    logic        commit_taken;
    logic        flush;
    logic        train_valid;
    logic [31:0] train_pc;
    logic        train_taken;
    logic [15:0] train_ghr;
    logic        mispredict;
    logic [15:0] recover_ghr;
    logic [4:0]  count;
    logic        underflow_err;
`ifdef BPQ_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks;
    int failures;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_pc;

    bp_commit_queue #(
        .DEPTH(16),
        .GHR_WIDTH(16),
        .SUM_WIDTH(8),
        .THETA(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .alloc_pc(alloc_pc),
        .alloc_pred(alloc_pred),
        .alloc_ghr(alloc_ghr),
        .alloc_sum(alloc_sum),
        .commit_valid(commit_valid),
        .commit_taken(commit_taken),
        .flush(flush),
        .train_valid(train_valid),
        .train_pc(train_pc),
        .train_taken(train_taken),
        .train_ghr(train_ghr),
        .mispredict(mispredict),
        .recover_ghr(recover_ghr),
        .count(count),
        .underflow_err(underflow_err)
`ifdef BPQ_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid  = 1'b0;
        commit_valid = 1'b0;
        commit_taken = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic pred,
                            input logic [15:0] ghr, input logic [7:0] sum);
        alloc_valid = 1'b1;
        alloc_pc    = pc;
        alloc_pred  = pred;
        alloc_ghr   = ghr;
        alloc_sum   = sum;
        tick();
        idle_inputs();
    endtask

    task automatic do_commit(input logic taken);
        commit_valid = 1'b1;
        commit_taken = taken;
        tick();
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();
        alloc_pc  = '0;
        alloc_pred = 1'b0;
        alloc_ghr = '0;
        alloc_sum = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(alloc_ready), 32'd1);
        chk("rst_train_valid", 32'(train_valid), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_underflow", 32'(underflow_err), 32'd0);
        chk("rst_train_pc", train_pc, 32'd0);
        chk("rst_recover_ghr", 32'(recover_ghr), 32'd0);

        // Three allocations
        do_alloc(32'h100, 1'b1, 16'h0011, 8'd20);
        do_alloc(32'h104, 1'b0, 16'h0022, 8'hFD);
        do_alloc(32'h108, 1'b1, 16'h0033, 8'd9);
        chk("alloc3_count", 32'(count), 32'd3);

        // Correct, confident (|20| > 8): no training
        do_commit(1'b1);
        chk("c1_train_valid", 32'(train_valid), 32'd0);
        chk("c1_mispredict", 32'(mispredict), 32'd0);
        chk("c1_count", 32'(count), 32'd2);

        // Correct, low confidence (|-3| <= 8): train
        do_commit(1'b0);
        chk("c2_train_valid", 32'(train_valid), 32'd1);
        chk("c2_train_pc", train_pc, 32'h104);
        chk("c2_train_taken", 32'(train_taken), 32'd0);
        chk("c2_train_ghr", 32'(train_ghr), 32'h0022);
        chk("c2_mispredict", 32'(mispredict), 32'd0);
        chk("c2_count", 32'(count), 32'd1);
        tick();
        chk("c2_pulse_drop", 32'(train_valid), 32'd0);
        chk("c2_pc_hold", train_pc, 32'h104);

        // Mispredict self-flush
        do_alloc(32'h200, 1'b1, 16'h00F0, 8'd50);
        do_alloc(32'h204, 1'b0, 16'h00F1, 8'd1);
        chk("mp_pre_count", 32'(count), 32'd3);
        do_commit(1'b1);   // 0x108, sum 9 > THETA
        chk("c3_train_valid", 32'(train_valid), 32'd0);
        chk("c3_count", 32'(count), 32'd2);
        do_commit(1'b0);   // 0x200 predicted taken
        chk("mp_mispredict", 32'(mispredict), 32'd1);
        chk("mp_train_valid", 32'(train_valid), 32'd1);
        chk("mp_train_pc", train_pc, 32'h200);
        chk("mp_recover_ghr", 32'(recover_ghr), 32'h01E0);
        chk("mp_count", 32'(count), 32'd0);
        tick();
        chk("mp_pulse_drop", 32'(mispredict), 32'd0);
        chk("mp_count_after", 32'(count), 32'd0);

        // Most-negative sum saturates to 127 > THETA: no training
        do_alloc(32'h300, 1'b0, 16'h0000, 8'h80);
        do_commit(1'b0);
        chk("sat_train_valid", 32'(train_valid), 32'd0);
        chk("sat_mispredict", 32'(mispredict), 32'd0);

        // Fill to 16 (sum 8 sits on the threshold, so every commit trains)
        for (int i = 0; i < 16; i++) begin
            do_alloc(32'h1000 + 32'(i * 4), 1'b1, 16'(i), 8'd8);
            exp_pc_q.push_back(32'h1000 + 32'(i * 4));
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        do_alloc(32'hDEAD, 1'b1, 16'h0, 8'd8);
        chk("drop_count", 32'(count), 32'd16);

        // Pop one, then commit+alloc for 20 cycles across the wrap
        do_commit(1'b1);
        exp_pc = exp_pc_q.pop_front();
        chk("wrap_first_pc", train_pc, exp_pc);
        chk("wrap_first_count", 32'(count), 32'd15);
        for (int j = 0; j < 20; j++) begin
            alloc_valid  = 1'b1;
            alloc_pc     = 32'h2000 + 32'(j * 4);
            alloc_pred   = 1'b1;
            alloc_ghr    = 16'(j);
            alloc_sum    = 8'd8;
            commit_valid = 1'b1;
            commit_taken = 1'b1;
            exp_pc_q.push_back(32'h2000 + 32'(j * 4));
            tick();
            idle_inputs();
            exp_pc = exp_pc_q.pop_front();
            chk("wrap_train_valid", 32'(train_valid), 32'd1);
            chk("wrap_train_pc", train_pc, exp_pc);
            chk("wrap_count", 32'(count), 32'd15);
        end

        // Plain flush empties the queue
        flush = 1'b1;
        tick();
        idle_inputs();
        chk("flush_count", 32'(count), 32'd0);

        // Commit while empty
        do_commit(1'b1);
        chk("uf_err", 32'(underflow_err), 32'd1);
        chk("uf_train_valid", 32'(train_valid), 32'd0);
        chk("uf_mispredict", 32'(mispredict), 32'd0);
        chk("uf_count", 32'(count), 32'd0);
        tick();
        chk("uf_sticky", 32'(underflow_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("uf_rst_clear", 32'(underflow_err), 32'd0);

        // Flush together with a commit and an alloc
        do_alloc(32'h400, 1'b1, 16'h0044, 8'd2);
        do_alloc(32'h404, 1'b1, 16'h0045, 8'd2);
        alloc_valid  = 1'b1;
        alloc_pc     = 32'h408;
        commit_valid = 1'b1;
        commit_taken = 1'b1;
        flush        = 1'b1;
        tick();
        idle_inputs();
        chk("fc_train_valid", 32'(train_valid), 32'd1);
        chk("fc_train_pc", train_pc, 32'h400);
        chk("fc_mispredict", 32'(mispredict), 32'd0);
        chk("fc_count", 32'(count), 32'd0);
`ifdef BPQ_STATS_EN
        chk("fc_stat_branches", stat_branches, 32'd1);
        chk("fc_stat_mispredicts", stat_mispredicts, 32'd0);
`endif

        // Mispredict with taken = 1: recovered history shifts in a 1
        do_alloc(32'h500, 1'b0, 16'h8001, 8'd30);
        do_commit(1'b1);
        chk("mp2_mispredict", 32'(mispredict), 32'd1);
        chk("mp2_recover_ghr", 32'(recover_ghr), 32'h0003);
        chk("mp2_train_taken", 32'(train_taken), 32'd1);
`ifdef BPQ_STATS_EN
        chk("mp2_stat_branches", stat_branches, 32'd2);
        chk("mp2_stat_mispredicts", stat_mispredicts, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
